femto_bus_ctrl: RTL and testbench

Memory/IO bus controller sitting directly downstream of the FemtoRV32 core's memory port. It consumes `mem_addr`/`mem_wdata`/`mem_wmask`/`mem_rstrb` and produces `mem_rdata`/`mem_rbusy`/`mem_wbusy`. Requests are decoded to an internal byte-writable synchronous RAM (zero wait states) or to an external IO page, which uses a req/ack handshake with an optional timeout. Only one transaction is in flight at a time, matching the core's non-pipelined FSM.

---
 rtl/femto_bus_ctrl_if.sv | 34 +++
 rtl/femto_bus_ctrl.sv | 134 +++++++++++++
 tb/tb_femto_bus_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/femto_bus_ctrl_if.sv
// rtl/femto_bus_ctrl_if.sv - core memory port and IO page signals of femto_bus_ctrl
interface femto_bus_ctrl_if;
  // core side
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic        mem_rbusy;
  logic        mem_wbusy;
  // IO page side
  logic [7:0]  io_addr;
  logic [31:0] io_wdata;
  logic [3:0]  io_wmask;
  logic        io_rd;
  logic        io_wr;
  logic [31:0] io_rdata;
  logic        io_ack;
  logic        bus_err;

  // the controller
  modport slave (
    input  mem_addr, mem_wdata, mem_wmask, mem_rstrb, io_rdata, io_ack,
    output mem_rdata, mem_rbusy, mem_wbusy, io_addr, io_wdata, io_wmask,
           io_rd, io_wr, bus_err
  );

  // the core plus the IO device
  modport master (
    output mem_addr, mem_wdata, mem_wmask, mem_rstrb, io_rdata, io_ack,
    input  mem_rdata, mem_rbusy, mem_wbusy, io_addr, io_wdata, io_wmask,
           io_rd, io_wr, bus_err
  );
endinterface

// File: rtl/femto_bus_ctrl.sv
// rtl/femto_bus_ctrl.sv - FemtoRV32 memory/IO bus controller (optional IO timeout: BUS_TIMEOUT_EN)
module femto_bus_ctrl #(
  parameter int ADDR_WIDTH = 24,
  parameter int RAM_WORDS  = 4096,
  parameter int IO_BIT     = 22,
  parameter int IO_TIMEOUT = 255
) (
  input logic               clk,
  input logic               reset,
  femto_bus_ctrl_if.slave   bus
);
  localparam int AW = $clog2(RAM_WORDS);

  typedef enum logic [1:0] {IDLE, IO_READ, IO_WRITE} state_t;
  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] addr;
  logic        is_idle, io_hit, wr_req, ram_wr, ram_rd, io_wr_start, io_rd_start;
  logic        timeout;
  logic        sel_io;
  logic [31:0] io_q, ram_q;
  logic [31:0] ram [RAM_WORDS];
  logic [AW-1:0] ram_idx;
  logic        unused_addr;

  // Bits above ADDR_WIDTH and the byte offset are not decoded.
  assign unused_addr = ^bus.mem_addr;

  assign addr        = bus.mem_addr[ADDR_WIDTH-1:0];
  assign ram_idx     = addr[AW+1:2];
  assign is_idle     = (state == IDLE);
  assign io_hit      = addr[IO_BIT];
  assign wr_req      = |bus.mem_wmask;
  // a write beats a simultaneous read strobe
  assign ram_wr      = is_idle && !io_hit && wr_req;
  assign ram_rd      = is_idle && !io_hit && !wr_req && bus.mem_rstrb;
  assign io_wr_start = is_idle && io_hit && wr_req;
  assign io_rd_start = is_idle && io_hit && !wr_req && bus.mem_rstrb;

`ifdef BUS_TIMEOUT_EN
  localparam int CW = ($clog2(IO_TIMEOUT + 1) > 8) ? $clog2(IO_TIMEOUT + 1) : 8;
  logic [CW-1:0] cnt;
  // abort on the edge where the pending count would reach IO_TIMEOUT; ack has priority
  assign timeout = !is_idle && !bus.io_ack && ((cnt + 1'b1) == CW'(IO_TIMEOUT));
`else
  localparam int unused_io_timeout = IO_TIMEOUT;
  assign timeout = 1'b0;
`endif

  // Synchronous RAM: byte-lane writes and registered read word, never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_wr && bus.mem_wmask[i])
        ram[ram_idx][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
    end
    if (ram_rd)
      ram_q <= ram[ram_idx];
  end

  // FSM state register; reset aborts any pending IO access at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (io_wr_start)      state_next = IO_WRITE;
        else if (io_rd_start) state_next = IO_READ;
      end
      IO_READ, IO_WRITE: begin
        if (bus.io_ack || timeout) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs decoded straight from the state register.
  always_comb begin
    bus.io_rd     = (state == IO_READ);
    bus.io_wr     = (state == IO_WRITE);
    bus.mem_rbusy = (state == IO_READ);
    bus.mem_wbusy = (state == IO_WRITE);
  end

  // IO request latches, IO read-data register and read-source select.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.io_addr  <= '0;
      bus.io_wdata <= '0;
      bus.io_wmask <= '0;
      io_q         <= '0;
      sel_io       <= 1'b1;
    end else begin
      if (io_wr_start) begin
        bus.io_addr  <= addr[9:2];
        bus.io_wdata <= bus.mem_wdata;
        bus.io_wmask <= bus.mem_wmask;
      end else if (io_rd_start) begin
        bus.io_addr  <= addr[9:2];
      end
      if (ram_rd)
        sel_io <= 1'b0;
      if (state == IO_READ && bus.io_ack) begin
        io_q   <= bus.io_rdata;
        sel_io <= 1'b1;
      end else if (state == IO_READ && timeout) begin
        io_q   <= 32'hFFFF_FFFF;
        sel_io <= 1'b1;
      end
    end
  end

`ifdef BUS_TIMEOUT_EN
  // Pending-cycle counter (zero while idle) and sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      bus.bus_err <= 1'b0;
    end else begin
      cnt <= is_idle ? '0 : cnt + 1'b1;
      if (timeout)
        bus.bus_err <= 1'b1;
    end
  end
`else
  assign bus.bus_err = 1'b0;
`endif

  assign bus.mem_rdata = sel_io ? io_q : ram_q;
endmodule

// File: tb/tb_femto_bus_ctrl.sv
// tb/tb_femto_bus_ctrl.sv - scoreboard bench for femto_bus_ctrl
module tb_femto_bus_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   passes = 0;
  logic [31:0] exp_q[$];
  logic rd_wait = 1'b0;
  int   wait_cycles = 0;

  femto_bus_ctrl_if bus();

  femto_bus_ctrl #(
    .ADDR_WIDTH(24), .RAM_WORDS(256), .IO_BIT(22), .IO_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: a read strobe opens a response window; the response is the first
  // cycle after the strobe edge with mem_rbusy low.
  always @(posedge clk) begin
    logic strobe;
    strobe = bus.mem_rstrb && (bus.mem_wmask == 4'b0);
    #1;
    if (rd_wait) begin
      if (!bus.mem_rbusy) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL read_response: got %h, expected no response", bus.mem_rdata);
        end else begin
          check("read_data", bus.mem_rdata, exp_q.pop_front());
        end
        rd_wait = 1'b0;
      end else if (++wait_cycles > 64) begin
        checks++;
        $display("FAIL read_wait: mem_rbusy still 1 after 64 cycles, expected 0");
        rd_wait = 1'b0;
      end
    end
    if (strobe) begin
      rd_wait = 1'b1;
      wait_cycles = 0;
    end
  end

  task automatic ram_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    bus.mem_addr = a; bus.mem_wdata = d; bus.mem_wmask = m;
    @(negedge clk);
    bus.mem_wmask = 4'b0;
  endtask

  task automatic read_req(input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    bus.mem_addr = a; bus.mem_rstrb = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.mem_rstrb = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_wmask = '0; bus.mem_rstrb = 1'b0;
    bus.io_rdata = '0; bus.io_ack = 1'b0;

    #1 reset = 1'b1;
    #2;
    check("rst_rbusy", bus.mem_rbusy, 0);
    check("rst_wbusy", bus.mem_wbusy, 0);
    check("rst_io_rd", bus.io_rd, 0);
    check("rst_io_wr", bus.io_wr, 0);
    check("rst_bus_err", bus.bus_err, 0);
    check("rst_io_addr", bus.io_addr, 0);
    check("rst_io_wdata", bus.io_wdata, 0);
    check("rst_io_wmask", bus.io_wmask, 0);
    check("rst_rdata", bus.mem_rdata, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // RAM word write then read
    ram_write(32'h10, 32'hCAFEBABE, 4'hF);
    read_req(32'h10, 32'hCAFEBABE);
    check("ram_rd_rbusy_0", bus.mem_rbusy, 0);
    @(negedge clk);
    check("ram_rd_rbusy_1", bus.mem_rbusy, 0);
    check("ram_wr_wbusy", bus.mem_wbusy, 0);

    // byte lane merge
    ram_write(32'h20, 32'h11223344, 4'hF);
    ram_write(32'h20, 32'h00AA0000, 4'b0100);
    read_req(32'h20, 32'h11AA3344);

    // index wraps modulo RAM_WORDS (256 words -> bit 10 ignored)
    read_req(32'h410, 32'hCAFEBABE);

    // write and read strobe together: write done, read ignored
    @(negedge clk);
    bus.mem_addr = 32'h30; bus.mem_wdata = 32'h55667788; bus.mem_wmask = 4'hF; bus.mem_rstrb = 1'b1;
    @(negedge clk);
    bus.mem_wmask = 4'b0; bus.mem_rstrb = 1'b0;
    check("collide_rdata_hold", bus.mem_rdata, 32'hCAFEBABE);
    read_req(32'h30, 32'h55667788);

    // stray io_ack in IDLE
    @(negedge clk);
    bus.io_rdata = 32'h99999999; bus.io_ack = 1'b1;
    @(negedge clk);
    bus.io_ack = 1'b0; bus.io_rdata = '0;
    check("idle_ack_rdata", bus.mem_rdata, 32'h55667788);
    check("idle_ack_io_rd", bus.io_rd, 0);

    // IO read with ack 3 cycles after io_rd, plus an ignored RAM write while pending
    ram_write(32'h40, 32'h01010101, 4'hF);
    read_req(32'h400008, 32'h12345678);
    check("io_rd_high", bus.io_rd, 1);
    check("io_rd_addr", bus.io_addr, 8'd2);
    check("io_rd_rbusy", bus.mem_rbusy, 1);
    bus.mem_addr = 32'h40; bus.mem_wdata = 32'hDEADDEAD; bus.mem_wmask = 4'hF;
    @(negedge clk);
    bus.mem_wmask = 4'b0;
    @(negedge clk);
    check("io_rd_pending", bus.mem_rbusy, 1);
    bus.io_rdata = 32'h12345678; bus.io_ack = 1'b1;
    @(negedge clk);
    bus.io_ack = 1'b0; bus.io_rdata = '0;
    check("io_rd_done_rbusy", bus.mem_rbusy, 0);
    check("io_rd_done_io_rd", bus.io_rd, 0);
    read_req(32'h40, 32'h01010101);

    // IO write
    @(negedge clk);
    bus.mem_addr = 32'h400004; bus.mem_wdata = 32'h0000BEEF; bus.mem_wmask = 4'b0011;
    @(negedge clk);
    bus.mem_wmask = 4'b0;
    check("io_wr_high", bus.io_wr, 1);
    check("io_wr_addr", bus.io_addr, 8'd1);
    check("io_wr_wmask", bus.io_wmask, 4'b0011);
    check("io_wr_wdata", bus.io_wdata, 32'h0000BEEF);
    check("io_wr_wbusy", bus.mem_wbusy, 1);
    check("io_wr_rbusy", bus.mem_rbusy, 0);
    @(negedge clk);
    check("io_wr_pending", bus.mem_wbusy, 1);
    bus.io_ack = 1'b1;
    @(negedge clk);
    bus.io_ack = 1'b0;
    check("io_wr_done_wbusy", bus.mem_wbusy, 0);
    check("io_wr_done_io_wr", bus.io_wr, 0);

`ifdef BUS_TIMEOUT_EN
    // IO read never acked: abort after 4 pending cycles
    read_req(32'h400000, 32'hFFFFFFFF);
    check("to_pending_0", bus.mem_rbusy, 1);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("to_pending", bus.mem_rbusy, 1);
    end
    @(negedge clk);
    check("to_abort_rbusy", bus.mem_rbusy, 0);
    check("to_bus_err", bus.bus_err, 1);
    read_req(32'h10, 32'hCAFEBABE);
    @(negedge clk);
    check("to_bus_err_sticky", bus.bus_err, 1);
`endif

    // async reset in the middle of an IO read
    read_req(32'h40000C, 32'h0);
    check("rst_mid_io_rd_before", bus.io_rd, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_io_rd", bus.io_rd, 0);
    check("rst_mid_rbusy", bus.mem_rbusy, 0);
    check("rst_mid_io_addr", bus.io_addr, 0);
    check("rst_mid_bus_err", bus.bus_err, 0);
    @(negedge clk);
    reset = 1'b0;
    read_req(32'h10, 32'hCAFEBABE);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("no_read_pending", rd_wait, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
